// File: rtl/memory_channel_requester.sv
// memory_channel_requester
// Client-side port for one channel of a round-robin main-memory controller.
// Takes a single load/store from a CPU client, holds it on the controller
// channel until this channel's grant slot accepts it, then waits for the
// one-cycle-later response (or an error/timeout) and returns it to the client
// as a held response. Only one transaction is ever outstanding.
//
// Ports:
//   clock, clear                 - rising-edge clock, async active-high reset
//   req_*                        - client request (valid/ready handshake)
//   resp_*                       - client response (valid/ready handshake)
//   ch_to_controller_*           - request toward the controller
//   controller_to_ch_*           - response from the controller
//   busy                         - a transaction is in flight
//   error_count                  - saturating count of error responses
module memory_channel_requester #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TIMEOUT_WIDTH  = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_write_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_error,
    output logic [DATA_WIDTH-1:0]    resp_read_data,
    output logic                     ch_to_controller_valid,
    input  logic                     ch_to_controller_ready,
    output logic                     ch_to_controller_write,
    output logic [ADDRESS_WIDTH-1:0] ch_to_controller_address,
    output logic [DATA_WIDTH-1:0]    ch_to_controller_write_data,
    input  logic                     controller_to_ch_valid,
    output logic                     controller_to_ch_ready,
    input  logic                     controller_to_ch_error,
    input  logic [DATA_WIDTH-1:0]    controller_to_ch_read_data,
    output logic                     busy,
    output logic [7:0]               error_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_AWAIT   = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_write;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic                     r_resp_error;
    logic [DATA_WIDTH-1:0]    r_resp_data;
    logic [TIMEOUT_WIDTH-1:0] r_timer;
    logic [7:0]               r_error_count;

    logic                     w_accept;
    logic                     w_capture;
    logic                     w_cap_error;
    logic [DATA_WIDTH-1:0]    w_cap_data;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_cap_error  = 1'b0;
        w_cap_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // No timeout here: the grant slot always comes back around.
                if (ch_to_controller_ready) w_next_state = S_AWAIT;
            end
            S_AWAIT: begin
                if (controller_to_ch_valid) begin
                    w_capture  = 1'b1;
                    w_cap_data = r_write ? '0 : controller_to_ch_read_data;
                end else if (r_timer == '0 && controller_to_ch_error) begin
                    // The error line is shared; it only belongs to us in the
                    // first cycle after acceptance.
                    w_capture   = 1'b1;
                    w_cap_error = 1'b1;
                end else if (r_timer == TIMER_LAST) begin
                    w_capture   = 1'b1;
                    w_cap_error = 1'b1;
                end
                if (w_capture) w_next_state = S_RESPOND;
            end
            S_RESPOND: begin
                if (resp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_address     <= '0;
            r_write_data  <= '0;
            r_resp_error  <= 1'b0;
            r_resp_data   <= '0;
            r_timer       <= '0;
            r_error_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_write      <= req_write;
                r_address    <= req_address;
                r_write_data <= req_write_data;
            end
            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_AWAIT && !w_capture) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_capture) begin
                r_resp_error <= w_cap_error;
                r_resp_data  <= w_cap_data;
                if (w_cap_error && r_error_count != 8'hFF) begin
                    r_error_count <= r_error_count + 8'd1;
                end
            end
        end
    end

    assign req_ready                   = (r_state == S_IDLE);
    assign resp_valid                  = (r_state == S_RESPOND);
    assign resp_error                  = r_resp_error;
    assign resp_read_data              = r_resp_data;
    assign ch_to_controller_valid      = (r_state == S_ISSUE);
    assign ch_to_controller_write      = r_write;
    assign ch_to_controller_address    = r_address;
    assign ch_to_controller_write_data = r_write_data;
    assign controller_to_ch_ready      = (r_state == S_AWAIT);
    assign busy                        = (r_state != S_IDLE);
    assign error_count                 = r_error_count;

endmodule

// File: tb/tb_memory_channel_requester.sv
module tb_memory_channel_requester;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_write_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_error;
    logic [31:0] resp_read_data;
    logic        ch_valid;
    logic        ch_ready = 1'b0;
    logic        ch_write;
    logic [31:0] ch_address;
    logic [31:0] ch_write_data;
    logic        ctrl_valid = 1'b0;
    logic        ctrl_ready;
    logic        ctrl_error = 1'b0;
    logic [31:0] ctrl_rdata = '0;
    logic        busy;
    logic [7:0]  error_count;

    memory_channel_requester #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(15), .TIMEOUT_WIDTH(4)
    ) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_error(resp_error),
        .resp_read_data(resp_read_data),
        .ch_to_controller_valid(ch_valid), .ch_to_controller_ready(ch_ready),
        .ch_to_controller_write(ch_write), .ch_to_controller_address(ch_address),
        .ch_to_controller_write_data(ch_write_data),
        .controller_to_ch_valid(ctrl_valid), .controller_to_ch_ready(ctrl_ready),
        .controller_to_ch_error(ctrl_error), .controller_to_ch_read_data(ctrl_rdata),
        .busy(busy), .error_count(error_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected responses in issue order.
    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    int   n_resp = 0;

    always @(negedge clock) begin
        if (resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                chk("resp_data", resp_read_data, e.data);
            end
            n_resp++;
        end
    end

    // Controller / memory stub. grant_mode: 0 = grant at once, 1 = every 3rd
    // ISSUE cycle, 2 = never. resp_mode: 0 = data, 1 = error flag, 2 = silent.
    int          grant_mode = 0;
    int          resp_mode  = 0;
    int          inject_cyc = -1;
    int          issue_idx  = 0;
    int          accept_cnt = 0;
    int          acc_cyc    = 0;
    logic        pend       = 1'b0;
    logic        s_write    = 1'b0;
    logic [31:0] s_addr     = '0;
    logic [31:0] s_wdata    = '0;
    logic [31:0] mem [logic [31:0]];

    always @(negedge clock) begin
        ctrl_valid = 1'b0;
        ctrl_error = 1'b0;
        ctrl_rdata = '0;
        if (pend) begin
            pend = 1'b0;
            accept_cnt++;
            if (resp_mode == 0) begin
                ctrl_valid = 1'b1;
                if (s_write) mem[s_addr] = s_wdata;
                else ctrl_rdata = mem.exists(s_addr) ? mem[s_addr] : 32'd0;
            end else if (resp_mode == 1) begin
                ctrl_error = 1'b1;
            end
        end
        if (cyc == inject_cyc) begin
            ctrl_valid = 1'b1;
            ctrl_rdata = 32'hBAD0BAD0;
        end
        ch_ready = 1'b0;
        if (ch_valid) begin
            if (grant_mode == 0 || (grant_mode == 1 && issue_idx % 3 == 2)) begin
                ch_ready = 1'b1;
                pend     = 1'b1;
                s_write  = ch_write;
                s_addr   = ch_address;
                s_wdata  = ch_write_data;
                acc_cyc  = cyc + 1;
            end
            issue_idx++;
        end else begin
            issue_idx = 0;
        end
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic push, input logic e_err, input logic [31:0] e_data);
        int n;
        exp_t e;
        if (push) begin
            e.err = e_err;
            e.data = e_data;
            q.push_back(e);
        end
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = w; req_address = a; req_write_data = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        int n;
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!resp_valid) chk("resp_wait_timeout", 32'd0, 32'd1);
        lat = cyc - acc_cyc;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, a0, nv, r0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("rst_ctrl_ready", {31'd0, ctrl_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err_cnt", {24'd0, error_count}, 32'd0);
        chk("rst_ch_addr", ch_address, 32'd0);
        @(posedge clock); #1;
        clear = 1'b0;

        // Store then load through the memory stub
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        wait_done();
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        wait_resp(lat);
        chk("load_latency", lat, 32'd1);
        wait_done();

        // Grant arrives on the third ISSUE cycle
        grant_mode = 1;
        a0 = accept_cnt;
        r0 = n_resp;
        nv = 0;
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        repeat (10) begin
            @(negedge clock);
            if (ch_valid) begin
                nv++;
                chk("grant_addr", ch_address, 32'h10);
                chk("grant_write", {31'd0, ch_write}, 32'd0);
            end
        end
        wait_done();
        chk("grant_valid_cycles", nv, 32'd3);
        chk("grant_accepts", accept_cnt - a0, 32'd1);
        chk("grant_responses", n_resp - r0, 32'd1);
        grant_mode = 0;

        // Controller error flag in the first AWAIT cycle
        resp_mode = 1;
        do_req(1'b0, 32'h2, 32'h0, 1'b1, 1'b1, 32'h0);
        wait_done();
        chk("err_count_1", {24'd0, error_count}, 32'd1);

        // No response at all -> timeout
        resp_mode = 2;
        do_req(1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0);
        wait_resp(lat);
        chk("timeout_latency", lat, 32'd15);
        wait_done();
        chk("err_count_2", {24'd0, error_count}, 32'd2);

        // Response backpressure
        resp_mode = 0;
        do_req(1'b1, 32'h20, 32'h12345678, 1'b1, 1'b0, 32'h0);
        wait_done();
        @(posedge clock); #1;
        resp_ready = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h12345678);
        wait_resp(lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_resp_data", resp_read_data, 32'h12345678);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            if (i < 4) @(negedge clock);
        end
        @(posedge clock); #1;
        resp_ready = 1'b1;
        wait_done();
        @(negedge clock);
        chk("bp_idle", {31'd0, busy}, 32'd0);

        // Clear during ISSUE, then a stray controller response
        grant_mode = 2;
        do_req(1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("abort_in_issue", {31'd0, ch_valid}, 32'd1);
        @(posedge clock); #1;
        clear = 1'b1;
        #1;
        chk("abort_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_err_cnt", {24'd0, error_count}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clock); #1;
        clear = 1'b0;
        inject_cyc = cyc;
        @(negedge clock);
        chk("stray_ctrl_ready", {31'd0, ctrl_ready}, 32'd0);
        repeat (4) begin
            @(negedge clock);
            chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("stray_busy", {31'd0, busy}, 32'd0);
        end
        grant_mode = 0;
        do_req(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        wait_done();

        chk("total_responses", n_resp, 32'd8);
        chk("queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_channel_requester.md
Name: memory_channel_requester

Overview:
- Upstream client port for one channel of the 3-channel round-robin main-memory controller.
- Accepts one load/store from a CPU client (fetch or load/store unit) with a valid/ready handshake and holds it on the controller channel until that channel's grant slot accepts it.
- Captures the one-cycle-later response, including the shared error flag, and returns it to the client as a held response with its own handshake.
- Has a single outstanding transaction and a timeout for responses that never arrive.

Parameters:
- ADDRESS_WIDTH, 32, width of byte addresses on both sides.
- DATA_WIDTH, 32, width of read/write data.
- TIMEOUT_CYCLES, 15, number of AWAIT cycles without a response before an error response is generated.
- TIMEOUT_WIDTH, 4, counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  single clock, rising edge.
- clear  in  1  reset, asynchronous, active-high; all state clears immediately on assertion.
- req_valid  in  1  client request valid.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ADDRESS_WIDTH  byte address.
- req_write_data  in  DATA_WIDTH  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  client consumes response.
- resp_error  out  1  request was rejected or timed out.
- resp_read_data  out  DATA_WIDTH  load data; 0 for stores and errors.
- ch_to_controller_valid  out  1  request to controller.
- ch_to_controller_ready  in  1  controller grant for this channel.
- ch_to_controller_write  out  1  registered req_write.
- ch_to_controller_address  out  ADDRESS_WIDTH  registered address.
- ch_to_controller_write_data  out  DATA_WIDTH  registered store data.
- controller_to_ch_valid  in  1  response valid from controller.
- controller_to_ch_ready  out  1  block can take a response.
- controller_to_ch_error  in  1  controller error flag (shared across channels).
- controller_to_ch_read_data  in  DATA_WIDTH  controller read data.
- busy  out  1  state != IDLE.
- error_count  out  8  saturating count of error responses.

Behaviour:

Reset:
- state = IDLE; every output = 0 except req_ready = 1 (combinational from IDLE).
- Latched request, response registers, timeout counter and error_count = 0.

IDLE:
- req_ready = 1.
- On req_valid: latch write/address/write_data; go to ISSUE.
- The request is never presented to the controller in the acceptance cycle.

ISSUE:
- ch_to_controller_valid = 1; fields driven from latched registers, stable until accepted.
- Accepted when ch_to_controller_valid & ch_to_controller_ready in the same cycle → AWAIT, timeout counter = 0.
- No timeout in ISSUE; the grant slot recurs every 3 cycles.

AWAIT:
- controller_to_ch_ready = 1.
- Priority 1: controller_to_ch_valid = 1 → capture read_data (forced 0 if the latched write = 1), error = 0; go to RESPOND.
- Priority 2: controller_to_ch_error is sampled only when the counter = 0, i.e. the first cycle after acceptance; later cycles may carry another channel's error.
  - If sampled error = 1: error = 1, data = 0; go to RESPOND.
- Priority 3: otherwise increment the counter.
  - When counter = TIMEOUT_CYCLES-1 and no response this cycle: error = 1, data = 0; go to RESPOND.
- Valid wins over error in the same cycle.

RESPOND:
- resp_valid = 1; resp_error and resp_read_data stable until resp_valid & resp_ready.
- On that handshake → IDLE.
- req_ready = 0 throughout, so there is no same-cycle overlap.
- Minimum request-to-request spacing is 4 cycles.

Outputs and counters:
- resp_read_data and resp_error are registered; ch_* outputs come from registers and state only.
- error_count increments by 1 on each transition into RESPOND with error = 1 and saturates at 255.

Boundary conditions:
- clear asserted mid-transaction: outputs drop in the same cycle and the transaction is abandoned. A late controller response arriving in IDLE is ignored (controller_to_ch_ready = 0).
- req_valid held through RESPOND: not accepted until IDLE.
- controller_to_ch_valid outside AWAIT: ignored.

Test Plan:
- Load: store 0xDEADBEEF at 0x10 via a memory stub, then load from 0x10 → read accepted on the first ready slot; resp_valid one cycle after AWAIT capture; resp_read_data = 0xDEADBEEF, resp_error = 0.
- Grant wait: ready pulses every 3rd cycle starting 2 cycles after ISSUE → ch_to_controller_valid held 3 cycles with constant address/data; single acceptance; exactly one response.
- Controller error: load address 0x00000002; stub drives error = 1, valid = 0 the cycle after accept → resp_error = 1, resp_read_data = 0, error_count = 1.
- Timeout: stub accepts but never responds and error = 0 → RESPOND entered exactly 15 cycles after accept with resp_error = 1; error_count increments.
- Backpressure: resp_ready low for 5 cycles after a load returning 0x12345678 → resp_valid and data stable for all 5; req_ready = 0; handshake returns to IDLE.
- Reset mid-op: assert clear during ISSUE, then inject controller_to_ch_valid one cycle later → all outputs 0 immediately; no resp_valid; busy = 0; next request completes normally.
